// File: rtl/ad9363_cmos_if_pkg.sv
// Shared encodings for the AD9363 CMOS RX deframer: lock FSM states,
// frame classes, frame patterns and the error counter width.
package ad9363_cmos_if_pkg;

  localparam int ERR_CNT_W = 16;

  localparam logic [1:0] FRAME_A0 = 2'b10;
  localparam logic [1:0] FRAME_A1 = 2'b01;

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } lock_state_t;

  typedef enum logic [1:0] {
    A0,
    A1,
    BAD
  } frame_class_t;

  // {frame_p, frame_n}: only the two alternating patterns are legal
  function automatic frame_class_t classify(input logic [1:0] frame);
    frame_class_t cls;
    cls = BAD;
    if (frame == FRAME_A0) cls = A0;
    else if (frame == FRAME_A1) cls = A1;
    return cls;
  endfunction

endpackage

// File: rtl/ad9363_rx_frame_lock.sv
// Frame classifier and lock state machine: acquires the frame alignment,
// tracks mismatches while locked and keeps the saturating error count.
module ad9363_rx_frame_lock
  import ad9363_cmos_if_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 frame_p,
  input  logic                 frame_n,
  input  logic                 err_clr,
  output logic                 sample_ok,
  output logic                 locked,
  output logic                 align_mode,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_CNT - 1);

  lock_state_t  state;
  frame_class_t cls;
  frame_class_t cand_cls;
  frame_class_t lock_cls;
  logic         cand_mode;
  logic [7:0]   good_cnt;
  logic [7:0]   miss_cnt;
  logic         mismatch;

  always_comb begin
    cls       = classify({frame_p, frame_n});
    cand_cls  = cand_mode ? A1 : A0;
    lock_cls  = align_mode ? A1 : A0;
    sample_ok = en && (state == LOCKED) && (cls == lock_cls);
    mismatch  = en && (state == LOCKED) && (cls != lock_cls);
  end

  // align_mode is deliberately left alone on loss of lock or disable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      cand_mode  <= 1'b0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      locked     <= 1'b0;
      align_mode <= 1'b0;
    end else if (!en) begin
      state    <= SEARCH;
      good_cnt <= '0;
      miss_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (cls != BAD) begin
            cand_mode <= (cls == A1);
            good_cnt  <= 8'd1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (cls == cand_cls) begin
            if (good_cnt == LOCK_LAST) begin
              state      <= LOCKED;
              locked     <= 1'b1;
              align_mode <= cand_mode;
              miss_cnt   <= '0;
              good_cnt   <= '0;
            end else begin
              good_cnt <= good_cnt + 8'd1;
            end
          end else begin
            state    <= SEARCH;
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (cls == lock_cls) begin
            miss_cnt <= '0;
          end else if (miss_cnt == LOSS_LAST) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            miss_cnt <= '0;
          end else begin
            miss_cnt <= miss_cnt + 8'd1;
          end
        end
        default: begin
          state    <= SEARCH;
          good_cnt <= '0;
          miss_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

  // Clear takes priority over a simultaneous increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ad9363_cmos_if_rx_deframer.sv
// AD9363 CMOS RX deframer top: input stage registers, frame lock and
// I/Q pair reassembly into a registered valid-strobed output.
module ad9363_cmos_if_rx_deframer
  import ad9363_cmos_if_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4
) (
  input  logic                 data_clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 rx_frame_p,
  input  logic                 rx_frame_n,
  input  logic [11:0]          rx_data_p,
  input  logic [11:0]          rx_data_n,
  input  logic                 err_clr,
  output logic                 adc_valid,
  output logic [11:0]          adc_data_i1,
  output logic [11:0]          adc_data_q1,
  output logic                 locked,
  output logic                 align_mode,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic        s0_frame_p;
  logic        s0_frame_n;
  logic [11:0] s0_data_p;
  logic [11:0] s0_data_n;
  logic [11:0] s1_data_n;
  logic        sample_ok;

  // s1_data_n supplies the falling-edge I sample for mode 1 pairs
  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_frame_p <= 1'b0;
      s0_frame_n <= 1'b0;
      s0_data_p  <= '0;
      s0_data_n  <= '0;
      s1_data_n  <= '0;
    end else begin
      s0_frame_p <= rx_frame_p;
      s0_frame_n <= rx_frame_n;
      s0_data_p  <= rx_data_p;
      s0_data_n  <= rx_data_n;
      s1_data_n  <= s0_data_n;
    end
  end

  ad9363_rx_frame_lock #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT)
  ) u_lock (
    .clk        (data_clk),
    .rst_n      (rst_n),
    .en         (rx_en),
    .frame_p    (s0_frame_p),
    .frame_n    (s0_frame_n),
    .err_clr    (err_clr),
    .sample_ok  (sample_ok),
    .locked     (locked),
    .align_mode (align_mode),
    .err_cnt    (err_cnt)
  );

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_valid   <= 1'b0;
      adc_data_i1 <= '0;
      adc_data_q1 <= '0;
    end else begin
      adc_valid <= sample_ok;
      if (sample_ok) begin
        adc_data_i1 <= align_mode ? s1_data_n : s0_data_p;
        adc_data_q1 <= align_mode ? s0_data_p : s0_data_n;
      end
    end
  end

endmodule
